// File: rtl/keycode_pkg.sv
// keycode_pkg: shared types and constants for the keycode event queue.
package keycode_pkg;

    // Make/break tracker states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        SWAP = 2'd2
    } kc_state_t;

    // Queued event payload. 'rpt' marks an auto-repeat make.
    typedef struct packed {
        logic       rpt;
        logic       make;
        logic [7:0] code;
    } kc_event_t;

    localparam int unsigned KC_EVENT_W = 10;
    localparam logic [7:0]  KC_NONE    = 8'h00;

    // Build an event payload from its fields.
    function automatic kc_event_t kc_event(input logic rpt, input logic make, input logic [7:0] code);
        kc_event_t e;
        e.rpt  = rpt;
        e.make = make;
        e.code = code;
        return e;
    endfunction

endpackage

// File: rtl/keycode_event_queue_fifo.sv
// sync_fifo: synchronous show-ahead FIFO with a registered head.
// The head register reflects entries stored before the current edge, so a
// push into an empty FIFO becomes visible one cycle after it is written.
module sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_full;
    logic             r_empty;

    logic             w_pop;
    logic             w_push;
    logic [CW-1:0]    w_count_nxt;
    logic [CW-1:0]    w_avail;
    logic [AW-1:0]    w_head_ptr;

    // A pop needs a visible head; a push into a full FIFO needs a same-cycle pop.
    assign w_pop      = i_pop && r_valid;
    assign w_push     = i_push && (!r_full || w_pop);
    assign w_avail    = r_count - CW'(w_pop);
    assign w_head_ptr = r_rd_ptr + AW'(w_pop);

    // Next occupancy; the push/pop gating keeps it inside 0..DEPTH.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; clear suppresses the write.
    always_ff @(posedge clk) begin
        if (w_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, occupancy and full/empty flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Show-ahead head register; data holds until the entry is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= (w_avail != '0);
            if (w_avail != '0) begin
                r_data <= r_mem[w_head_ptr];
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/keycode_event_queue.sv
// keycode_event_queue: turns the level HID keycode into queued make/break
// events handed out over valid/ready.
// Optional auto-repeat is built when KEYCODE_AUTOREPEAT_EN is defined.
module keycode_event_queue
    import keycode_pkg::*;
#(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    input  logic [7:0]             keycode,
    output logic                   evt_valid,
    output logic [9:0]             evt_data,
    input  logic                   evt_ready,
    output logic [$clog2(DEPTH):0] evt_count,
    output logic                   overflow,
    input  logic                   clear
);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_HELD = 2'(HELD);
    localparam logic [1:0] S_SWAP = 2'(SWAP);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [7:0]  r_cur_key;
    logic [7:0]  w_cur_key_nxt;
    logic [7:0]  r_pend_key;
    logic [7:0]  w_pend_key_nxt;
    logic        w_push;
    kc_event_t   w_push_evt;
    logic        w_rpt_fire;
    logic        r_overflow;

    logic        w_full;
    logic        w_empty;
    logic        w_pop;

    // Head is only ever valid with a non-empty FIFO; the empty term is a guard.
    assign w_pop = evt_valid && evt_ready && !w_empty;

`ifdef KEYCODE_AUTOREPEAT_EN
    // Reload value assumes REPEAT_PERIOD <= REPEAT_DELAY.
    localparam int unsigned  RPT_W      = $clog2(REPEAT_DELAY + 1);
    localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RPT_W-1:0] r_rpt_cnt;
    logic             w_hold;

    assign w_hold     = (r_state == S_HELD) && (keycode == r_cur_key);
    assign w_rpt_fire = w_hold && (r_rpt_cnt == RPT_FIRE);

    // Hold-time counter; any exit from a steady hold restarts it.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_rpt_cnt <= '0;
        end else if (clear || !w_hold) begin
            r_rpt_cnt <= '0;
        end else if (w_rpt_fire) begin
            r_rpt_cnt <= RPT_RELOAD;
        end else begin
            r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
        end
    end
`else
    assign w_rpt_fire = 1'b0;
`endif

    // Tracker state and held-key registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state    <= S_IDLE;
            r_cur_key  <= KC_NONE;
            r_pend_key <= KC_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_key  <= w_cur_key_nxt;
            r_pend_key <= w_pend_key_nxt;
        end
    end

    // Next-state and event generation; at most one push per cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_cur_key_nxt  = r_cur_key;
        w_pend_key_nxt = r_pend_key;
        w_push         = 1'b0;
        w_push_evt     = kc_event(1'b0, 1'b0, KC_NONE);

        if (clear) begin
            w_state_nxt    = S_IDLE;
            w_cur_key_nxt  = KC_NONE;
            w_pend_key_nxt = KC_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (keycode != KC_NONE) begin
                        w_push        = 1'b1;
                        w_push_evt    = kc_event(1'b0, 1'b1, keycode);
                        w_cur_key_nxt = keycode;
                        w_state_nxt   = S_HELD;
                    end
                end
                S_HELD: begin
                    if (keycode == r_cur_key) begin
                        if (w_rpt_fire) begin
                            w_push     = 1'b1;
                            w_push_evt = kc_event(1'b1, 1'b1, r_cur_key);
                        end
                    end else if (keycode == KC_NONE) begin
                        w_push        = 1'b1;
                        w_push_evt    = kc_event(1'b0, 1'b0, r_cur_key);
                        w_cur_key_nxt = KC_NONE;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_push         = 1'b1;
                        w_push_evt     = kc_event(1'b0, 1'b0, r_cur_key);
                        w_pend_key_nxt = keycode;
                        w_state_nxt    = S_SWAP;
                    end
                end
                S_SWAP: begin
                    // Make for the new key; the live keycode is re-evaluated next cycle.
                    w_push        = 1'b1;
                    w_push_evt    = kc_event(1'b0, 1'b1, r_pend_key);
                    w_cur_key_nxt = r_pend_key;
                    w_state_nxt   = S_HELD;
                end
                default: begin
                    w_state_nxt   = S_IDLE;
                    w_cur_key_nxt = KC_NONE;
                end
            endcase
        end
    end

    // Sticky drop flag: push into a full FIFO with no same-cycle pop.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;

    sync_fifo #(
        .WIDTH (KC_EVENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk_clk),
        .rst_n       (reset_reset_n),
        .i_clear     (clear),
        .i_push      (w_push),
        .i_push_data (w_push_evt),
        .i_pop       (w_pop),
        .o_valid     (evt_valid),
        .o_data      (evt_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (evt_count)
    );

endmodule

// File: tb/tb_keycode_event_queue.sv
// Self-checking bench for keycode_event_queue (DEPTH=8, repeat 20/5).
module tb_keycode_event_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk_clk = 1'b0;
    logic          reset_reset_n;
    logic [7:0]    keycode;
    logic          evt_valid;
    logic [9:0]    evt_data;
    logic          evt_ready;
    logic [CW-1:0] evt_count;
    logic          overflow;
    logic          clear;

    int            checks = 0;
    int            errors = 0;
    logic [9:0]    exp_q[$];
    logic [9:0]    want;

    always #5 clk_clk = ~clk_clk;

    keycode_event_queue #(
        .DEPTH         (DEPTH),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (5)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .keycode       (keycode),
        .evt_valid     (evt_valid),
        .evt_data      (evt_data),
        .evt_ready     (evt_ready),
        .evt_count     (evt_count),
        .overflow      (overflow),
        .clear         (clear)
    );

    function automatic logic [9:0] ev(input logic r, input logic m, input logic [7:0] c);
        return {r, m, c};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset_reset_n = 1'b0;
        keycode = 8'h00; evt_ready = 1'b0; clear = 1'b0;
        tick(3);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", evt_valid); end
        checks++; if (evt_data !== 10'h000) begin errors++; $display("FAIL reset_data got %h want 000", evt_data); end
        checks++; if (evt_count !== CW'(0)) begin errors++; $display("FAIL reset_count got %0d want 0", evt_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        reset_reset_n = 1'b1;
        tick(2);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", evt_valid); end
    endtask

    task automatic test_press_release;
        keycode = 8'h04; exp_q.push_back(ev(1'b0, 1'b1, 8'h04));
        tick(10);
        keycode = 8'h00; exp_q.push_back(ev(1'b0, 1'b0, 8'h04));
        tick(3);
        checks++; if (evt_count !== CW'(2)) begin errors++; $display("FAIL pr_count got %0d want 2", evt_count); end
        evt_ready = 1'b1;
        for (int cyc = 0; cyc < 50 && exp_q.size() != 0; cyc++) begin
            @(negedge clk_clk);
            if (evt_valid && evt_ready) begin
                want = exp_q.pop_front();
                checks++; if (evt_data !== want) begin errors++; $display("FAIL pr_event got %h want %h", evt_data, want); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL pr_timeout got %0d left want 0", exp_q.size()); exp_q.delete(); end
        tick(2);
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL pr_empty got %b want 0", evt_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pr_overflow got %b want 0", overflow); end
    endtask

    task automatic test_swap;
        evt_ready = 1'b0;
        keycode = 8'h04; exp_q.push_back(ev(1'b0, 1'b1, 8'h04));
        tick(3);
        checks++; if (evt_count !== CW'(1)) begin errors++; $display("FAIL swap_count1 got %0d want 1", evt_count); end
        keycode = 8'h16;
        exp_q.push_back(ev(1'b0, 1'b0, 8'h04));
        exp_q.push_back(ev(1'b0, 1'b1, 8'h16));
        tick(1);
        checks++; if (evt_count !== CW'(2)) begin errors++; $display("FAIL swap_count2 got %0d want 2", evt_count); end
        tick(1);
        checks++; if (evt_count !== CW'(3)) begin errors++; $display("FAIL swap_count3 got %0d want 3", evt_count); end
        checks++; if (evt_data !== 10'h104) begin errors++; $display("FAIL swap_head got %h want 104", evt_data); end
        tick(3);
        keycode = 8'h00; exp_q.push_back(ev(1'b0, 1'b0, 8'h16));
        tick(2);
        evt_ready = 1'b1;
        for (int cyc = 0; cyc < 50 && exp_q.size() != 0; cyc++) begin
            @(negedge clk_clk);
            if (evt_valid && evt_ready) begin
                want = exp_q.pop_front();
                checks++; if (evt_data !== want) begin errors++; $display("FAIL swap_event got %h want %h", evt_data, want); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL swap_timeout got %0d left want 0", exp_q.size()); exp_q.delete(); end
        tick(2);
        evt_ready = 1'b0;
    endtask

    task automatic test_overflow;
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            keycode = 8'h20 + 8'(i);
            if (exp_q.size() < DEPTH) exp_q.push_back(ev(1'b0, 1'b1, keycode));
            tick(2);
            if (exp_q.size() < DEPTH) exp_q.push_back(ev(1'b0, 1'b0, keycode));
            keycode = 8'h00;
            tick(2);
        end
        tick(2);
        checks++; if (evt_count !== CW'(8)) begin errors++; $display("FAIL ovf_count got %0d want 8", evt_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        evt_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && exp_q.size() != 0; cyc++) begin
            @(negedge clk_clk);
            if (evt_valid && evt_ready) begin
                want = exp_q.pop_front();
                checks++; if (evt_data !== want) begin errors++; $display("FAIL ovf_event got %h want %h", evt_data, want); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_timeout got %0d left want 0", exp_q.size()); exp_q.delete(); end
        tick(2);
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b want 0", evt_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        // Clear with a key held: queue flushed, then a fresh make appears.
        keycode = 8'h05;
        tick(2);
        checks++; if (evt_count !== CW'(1)) begin errors++; $display("FAIL clr_pre got %0d want 1", evt_count); end
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        checks++; if (evt_count !== CW'(0)) begin errors++; $display("FAIL clr_count got %0d want 0", evt_count); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %b want 0", evt_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow got %b want 0", overflow); end
        exp_q.push_back(ev(1'b0, 1'b1, 8'h05));
        tick(2);
        checks++; if (evt_count !== CW'(1)) begin errors++; $display("FAIL clr_remake got %0d want 1", evt_count); end
        keycode = 8'h00; exp_q.push_back(ev(1'b0, 1'b0, 8'h05));
        tick(1);
        evt_ready = 1'b1;
        for (int cyc = 0; cyc < 50 && exp_q.size() != 0; cyc++) begin
            @(negedge clk_clk);
            if (evt_valid && evt_ready) begin
                want = exp_q.pop_front();
                checks++; if (evt_data !== want) begin errors++; $display("FAIL clr_event got %h want %h", evt_data, want); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL clr_timeout got %0d left want 0", exp_q.size()); exp_q.delete(); end
        tick(2);
        evt_ready = 1'b0;
    endtask

    task automatic test_full_pop;
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            keycode = 8'h40 + 8'(i); exp_q.push_back(ev(1'b0, 1'b1, keycode));
            tick(2);
            exp_q.push_back(ev(1'b0, 1'b0, keycode)); keycode = 8'h00;
            tick(2);
        end
        checks++; if (evt_count !== CW'(8)) begin errors++; $display("FAIL fp_fill got %0d want 8", evt_count); end
        // Push and pop on the same edge while full.
        keycode = 8'h30; evt_ready = 1'b1; exp_q.push_back(ev(1'b0, 1'b1, 8'h30));
        @(negedge clk_clk);
        want = exp_q.pop_front();
        checks++; if (!evt_valid || evt_data !== want) begin errors++; $display("FAIL fp_head got %b/%h want 1/%h", evt_valid, evt_data, want); end
        @(posedge clk_clk); #1;
        evt_ready = 1'b0;
        checks++; if (evt_count !== CW'(8)) begin errors++; $display("FAIL fp_count got %0d want 8", evt_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fp_overflow got %b want 0", overflow); end
        keycode = 8'h00; evt_ready = 1'b1; exp_q.push_back(ev(1'b0, 1'b0, 8'h30));
        for (int cyc = 0; cyc < 80 && exp_q.size() != 0; cyc++) begin
            @(negedge clk_clk);
            if (evt_valid && evt_ready) begin
                want = exp_q.pop_front();
                checks++; if (evt_data !== want) begin errors++; $display("FAIL fp_event got %h want %h", evt_data, want); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fp_timeout got %0d left want 0", exp_q.size()); exp_q.delete(); end
        tick(2);
        evt_ready = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fp_overflow_end got %b want 0", overflow); end
    endtask

    task automatic test_reset_midstream;
        evt_ready = 1'b0;
        keycode = 8'h10; tick(2);
        keycode = 8'h00; tick(2);
        keycode = 8'h11; tick(2);
        checks++; if (evt_count !== CW'(3)) begin errors++; $display("FAIL rst_pre got %0d want 3", evt_count); end
        #2 reset_reset_n = 1'b0;
        #1;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", evt_valid); end
        checks++; if (evt_count !== CW'(0)) begin errors++; $display("FAIL rst_count got %0d want 0", evt_count); end
        keycode = 8'h2C;
        exp_q.delete();
        tick(2);
        #3 reset_reset_n = 1'b1;
        exp_q.push_back(ev(1'b0, 1'b1, 8'h2C));
        evt_ready = 1'b1;
        for (int cyc = 0; cyc < 50 && exp_q.size() != 0; cyc++) begin
            @(negedge clk_clk);
            if (evt_valid && evt_ready) begin
                want = exp_q.pop_front();
                checks++; if (evt_data !== want) begin errors++; $display("FAIL rst_event got %h want %h", evt_data, want); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_timeout got %0d left want 0", exp_q.size()); exp_q.delete(); end
        tick(4);
        checks++; if (evt_valid !== 1'b0 || evt_count !== CW'(0)) begin errors++; $display("FAIL rst_single got %b/%0d want 0/0", evt_valid, evt_count); end
        evt_ready = 1'b0;
        keycode = 8'h00;
        tick(4);
    endtask

`ifdef KEYCODE_AUTOREPEAT_EN
    task automatic test_autorepeat;
        evt_ready = 1'b0;
        keycode = 8'h1A; exp_q.push_back(ev(1'b0, 1'b1, 8'h1A));
        tick(20);
        checks++; if (evt_count !== CW'(1)) begin errors++; $display("FAIL ar_pre got %0d want 1", evt_count); end
        tick(1);
        checks++; if (evt_count !== CW'(2)) begin errors++; $display("FAIL ar_first got %0d want 2", evt_count); end
        tick(4);
        checks++; if (evt_count !== CW'(2)) begin errors++; $display("FAIL ar_gap got %0d want 2", evt_count); end
        tick(1);
        checks++; if (evt_count !== CW'(3)) begin errors++; $display("FAIL ar_second got %0d want 3", evt_count); end
        tick(14);
        keycode = 8'h00;
        for (int i = 0; i < 4; i++) exp_q.push_back(ev(1'b1, 1'b1, 8'h1A));
        exp_q.push_back(ev(1'b0, 1'b0, 8'h1A));
        tick(2);
        checks++; if (evt_count !== CW'(6)) begin errors++; $display("FAIL ar_total got %0d want 6", evt_count); end
        evt_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && exp_q.size() != 0; cyc++) begin
            @(negedge clk_clk);
            if (evt_valid && evt_ready) begin
                want = exp_q.pop_front();
                checks++; if (evt_data !== want) begin errors++; $display("FAIL ar_event got %h want %h", evt_data, want); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ar_timeout got %0d left want 0", exp_q.size()); exp_q.delete(); end
        tick(2);
        evt_ready = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_press_release();
        test_swap();
        test_overflow();
        test_full_pop();
        test_reset_midstream();
`ifdef KEYCODE_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
